data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: IDLE/REQ/WAIT/DONE handshake between core load/store and a req/gnt/rvalid memory port.
// Optional WAIT timeout with sticky bus_err when DMEM_TIMEOUT_EN is defined.
module data_mem_ctrl #(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load,
    input  logic                 mem_en,
    input  logic [DataWidth-1:0] addr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [3:0]           masking,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [3:0]           mem_mask,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 stall,
    output logic                 data_valid,
    output logic [DataWidth-1:0] wrap_load_in,
    output logic [1:0]           byteadd,
    output logic                 bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic                 is_load_q, is_load_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic                 data_valid_q, data_valid_d;
    logic                 bus_err_q, bus_err_d;
    logic [DataWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
    logic [DataWidth-1:0] wrap_q, wrap_d;
    logic [3:0]           mem_mask_q, mem_mask_d;
    logic [1:0]           addr_lo_q, addr_lo_d;
    logic [1:0]           byteadd_q, byteadd_d;
    logic                 timeout;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counts cycles spent in WAIT; fires on the TimeoutCycles-th cycle unless rvalid arrives.
    always_comb begin
        cnt_d = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
    end

    assign timeout = (state_q == WAIT) && !mem_rvalid && (cnt_q == 8'(TimeoutCycles - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        addr_lo_d    = addr_lo_q;
        wrap_d       = wrap_q;
        byteadd_d    = byteadd_q;
        data_valid_d = 1'b0;
        bus_err_d    = bus_err_q | timeout;
        case (state_q)
            IDLE: begin
                if (Load || mem_en) begin
                    // Load has priority; a simultaneous store is dropped.
                    is_load_d   = Load;
                    mem_addr_d  = {addr[DataWidth-1:2], 2'b00};
                    mem_wdata_d = wdata;
                    mem_mask_d  = masking;
                    addr_lo_d   = addr[1:0];
                    mem_req_d   = 1'b1;
                    mem_we_d    = !Load;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = is_load_q ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wrap_d       = mem_rdata;
                    byteadd_d    = addr_lo_q;
                    data_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (timeout) begin
                    wrap_d       = '0;
                    byteadd_d    = addr_lo_q;
                    data_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
            addr_lo_q    <= '0;
            wrap_q       <= '0;
            byteadd_q    <= '0;
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            addr_lo_q    <= addr_lo_d;
            wrap_q       <= wrap_d;
            byteadd_q    <= byteadd_d;
            data_valid_q <= data_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall        = ((state_q == IDLE) && (Load || mem_en)) || (state_q == REQ) || (state_q == WAIT);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_mask     = mem_mask_q;
    assign data_valid   = data_valid_q;
    assign wrap_load_in = wrap_q;
    assign byteadd      = byteadd_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: store, load, load/store collision, WAIT behaviour and reset abort.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        Load, mem_en;
    logic [31:0] addr, wdata;
    logic [3:0]  masking;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall, data_valid;
    logic [31:0] wrap_load_in;
    logic [1:0]  byteadd;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    data_mem_ctrl #(.DataWidth(32), .TimeoutCycles(255)) dut (
        .clk(clk), .rst(rst), .Load(Load), .mem_en(mem_en), .addr(addr),
        .wdata(wdata), .masking(masking), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .data_valid(data_valid), .wrap_load_in(wrap_load_in),
        .byteadd(byteadd), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; Load = 1'b0; mem_en = 1'b0; addr = '0; wdata = '0; masking = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wrap", wrap_load_in, 32'd0);
        chk("rst_byteadd", 32'(byteadd), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dvalid", 32'(data_valid), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        tick();

        // Store with immediate grant
        mem_en = 1'b1; addr = 32'h1006; wdata = 32'hDEADBEEF; masking = 4'b1100; mem_gnt = 1'b1;
        #1 chk("st_stall_idle", 32'(stall), 32'd1);
        tick();
        mem_en = 1'b0; addr = 32'h0; masking = 4'b0000;
        #1;
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h1004);
        chk("st_mask", 32'(mem_mask), 32'hC);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_stall_req", 32'(stall), 32'd1);
        tick();
        chk("st_done_req", 32'(mem_req), 32'd0);
        chk("st_done_we", 32'(mem_we), 32'd0);
        chk("st_done_stall", 32'(stall), 32'd0);
        chk("st_done_dvalid", 32'(data_valid), 32'd0);
        mem_gnt = 1'b0;
        tick();

        // Load 0x2003, grant delayed, rvalid one cycle after grant
        Load = 1'b1; addr = 32'h2003;
        tick();
        Load = 1'b0; addr = 32'h0;
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_addr", mem_addr, 32'h2000);
        tick();
        chk("ld_req_hold", 32'(mem_req), 32'd1);
        chk("ld_addr_hold", mem_addr, 32'h2000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("ld_wait_req", 32'(mem_req), 32'd0);
        chk("ld_wait_stall", 32'(stall), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hA1B2C3D4;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("ld_dvalid", 32'(data_valid), 32'd1);
        chk("ld_wrap", wrap_load_in, 32'hA1B2C3D4);
        chk("ld_byteadd", 32'(byteadd), 32'd3);
        chk("ld_done_stall", 32'(stall), 32'd0);
        tick();
        chk("ld_dvalid_pulse", 32'(data_valid), 32'd0);
        chk("ld_wrap_hold", wrap_load_in, 32'hA1B2C3D4);

        // Load and store together: load wins
        Load = 1'b1; mem_en = 1'b1; addr = 32'h3001; masking = 4'hF; wdata = 32'h12345678;
        tick();
        Load = 1'b0; mem_en = 1'b0;
        chk("both_req", 32'(mem_req), 32'd1);
        chk("both_we", 32'(mem_we), 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("both_wait_stall", 32'(stall), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_rvalid = 1'b0;
        chk("both_dvalid", 32'(data_valid), 32'd1);
        chk("both_wrap", wrap_load_in, 32'h11223344);
        chk("both_byteadd", 32'(byteadd), 32'd1);
        tick();

        // Long WAIT with no rvalid
        Load = 1'b1; addr = 32'h5002;
        tick();
        Load = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < 254; i++) tick();
        chk("to_pre_bus_err", 32'(bus_err), 32'd0);
        chk("to_pre_stall", 32'(stall), 32'd1);
        tick();
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_dvalid", 32'(data_valid), 32'd1);
        chk("to_wrap", wrap_load_in, 32'd0);
        tick();
        chk("to_bus_err_sticky", 32'(bus_err), 32'd1);
`else
        for (int i = 0; i < 300; i++) tick();
        chk("nto_stall", 32'(stall), 32'd1);
        chk("nto_bus_err", 32'(bus_err), 32'd0);
        chk("nto_dvalid", 32'(data_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("nto_wrap", wrap_load_in, 32'hCAFEF00D);
        chk("nto_byteadd", 32'(byteadd), 32'd2);
        tick();
`endif

        // Reset while in WAIT; later rvalid must be ignored
        Load = 1'b1; addr = 32'h4000;
        tick();
        Load = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rw_stall_wait", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_bus_err", 32'(bus_err), 32'd0);
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_dvalid", 32'(data_valid), 32'd0);
        chk("rw_wrap", wrap_load_in, 32'd0);
        chk("rw_stall_after", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
